// File: rtl/bsg_mcl_rcv_slot_scheduler_if.sv
// rtl/bsg_mcl_rcv_slot_scheduler_if.sv - slot-side and drain-side signals of the receive slot scheduler
interface bsg_mcl_rcv_slot_scheduler_if #(
  parameter int num_slots_p = 4,
  parameter int width_p     = 32,
  parameter int cnt_width_p = 16
);
  localparam int sid_w = (num_slots_p > 1) ? $clog2(num_slots_p) : 1;

  logic [num_slots_p-1:0]             en_mask_i;
  logic [num_slots_p-1:0]             v_i;
  logic [num_slots_p*width_p-1:0]     data_i;
  logic [num_slots_p-1:0]             yumi_o;
  logic                               v_o;
  logic [width_p-1:0]                 data_o;
  logic [sid_w-1:0]                   slot_id_o;
  logic                               last_o;
  logic                               ready_i;
  logic                               busy_o;
  logic [num_slots_p*cnt_width_p-1:0] pkt_cnt_o;

  modport master (
    output en_mask_i, v_i, data_i, ready_i,
    input  yumi_o, v_o, data_o, slot_id_o, last_o, busy_o, pkt_cnt_o
  );

  modport slave (
    input  en_mask_i, v_i, data_i, ready_i,
    output yumi_o, v_o, data_o, slot_id_o, last_o, busy_o, pkt_cnt_o
  );
endinterface

// File: rtl/bsg_mcl_rcv_slot_scheduler.sv
// rtl/bsg_mcl_rcv_slot_scheduler.sv - packet-locked round-robin drain of receive slots
module bsg_mcl_rcv_slot_scheduler #(
  parameter int num_slots_p = 4,
  parameter int width_p     = 32,
  parameter int beats_p     = 4,
  parameter int cnt_width_p = 16
) (
  input logic                        clk_i,
  input logic                        reset_n_i,
  bsg_mcl_rcv_slot_scheduler_if.slave bus
);
  localparam int sid_w = (num_slots_p > 1) ? $clog2(num_slots_p) : 1;
  localparam int bc_w  = (beats_p > 1) ? $clog2(beats_p) : 1;

  typedef enum logic {IDLE, LOCK} state_e;

  state_e                 state_r, state_n;
  logic [sid_w-1:0]       rr_ptr_r, rr_ptr_n;
  logic [sid_w-1:0]       grant_r, grant_n;
  logic [bc_w-1:0]        beat_cnt_r, beat_cnt_n;
  logic [cnt_width_p-1:0] cnt_r [num_slots_p];

  logic [num_slots_p-1:0] req;
  logic [sid_w-1:0]       pick;
  logic [sid_w-1:0]       sel;
  logic                   v;
  logic                   last;
  logic                   busy;
  logic                   done;
  logic [num_slots_p-1:0] yumi;

  function automatic logic [sid_w-1:0] wrap_inc(input logic [sid_w-1:0] x);
    return (int'(x) == num_slots_p - 1) ? '0 : x + 1'b1;
  endfunction

  assign req = bus.v_i & bus.en_mask_i;

  // First requester at or after rr_ptr_r, wrapping; slot 0 when nobody requests.
  always_comb begin
    int idx;
    logic found;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < num_slots_p; i++) begin
      idx = int'(rr_ptr_r) + i;
      if (idx >= num_slots_p) idx = idx - num_slots_p;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = sid_w'(idx);
      end
    end
  end

  always_comb begin
    state_n    = state_r;
    rr_ptr_n   = rr_ptr_r;
    grant_n    = grant_r;
    beat_cnt_n = beat_cnt_r;
    sel        = '0;
    v          = 1'b0;
    last       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    yumi       = '0;
    if (reset_n_i) begin
      case (state_r)
        IDLE: begin
          sel  = pick;
          v    = |req;
          last = (beats_p == 1);
          if (v && bus.ready_i) begin
            yumi[pick] = 1'b1;
            if (beats_p == 1) begin
              done     = 1'b1;
              rr_ptr_n = wrap_inc(pick);
            end else begin
              grant_n    = pick;
              beat_cnt_n = bc_w'(1);
              state_n    = LOCK;
            end
          end
        end
        LOCK: begin
          // Grant held for the whole packet: mask and other slots are ignored here.
          sel  = grant_r;
          v    = bus.v_i[grant_r];
          busy = 1'b1;
          last = (beat_cnt_r == bc_w'(beats_p - 1));
          if (v && bus.ready_i) begin
            yumi[grant_r] = 1'b1;
            beat_cnt_n    = beat_cnt_r + 1'b1;
            if (last) begin
              done       = 1'b1;
              rr_ptr_n   = wrap_inc(grant_r);
              beat_cnt_n = '0;
              state_n    = IDLE;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r    <= IDLE;
      rr_ptr_r   <= '0;
      grant_r    <= '0;
      beat_cnt_r <= '0;
      for (int i = 0; i < num_slots_p; i++) cnt_r[i] <= '0;
    end else begin
      state_r    <= state_n;
      rr_ptr_r   <= rr_ptr_n;
      grant_r    <= grant_n;
      beat_cnt_r <= beat_cnt_n;
      if (done) cnt_r[sel] <= cnt_r[sel] + 1'b1;
    end
  end

  assign bus.yumi_o    = yumi;
  assign bus.v_o       = v;
  assign bus.last_o    = last;
  assign bus.busy_o    = busy;
  assign bus.slot_id_o = sel;
  assign bus.data_o    = reset_n_i ? bus.data_i[int'(sel)*width_p +: width_p] : '0;

  always_comb begin
    for (int i = 0; i < num_slots_p; i++) bus.pkt_cnt_o[i*cnt_width_p +: cnt_width_p] = cnt_r[i];
  end
endmodule

// File: tb/tb_bsg_mcl_rcv_slot_scheduler.sv
// tb/tb_bsg_mcl_rcv_slot_scheduler.sv - directed self-checking bench for the receive slot scheduler
module tb_bsg_mcl_rcv_slot_scheduler;
  logic clk;
  logic reset_n;
  int   n_run;
  int   n_fail;

  bsg_mcl_rcv_slot_scheduler_if #(.num_slots_p(4), .width_p(32), .cnt_width_p(16)) a ();
  bsg_mcl_rcv_slot_scheduler_if #(.num_slots_p(4), .width_p(32), .cnt_width_p(4))  b ();

  bsg_mcl_rcv_slot_scheduler #(.num_slots_p(4), .width_p(32), .beats_p(4), .cnt_width_p(16)) u_dut4 (
    .clk_i(clk), .reset_n_i(reset_n), .bus(a.slave)
  );
  bsg_mcl_rcv_slot_scheduler #(.num_slots_p(4), .width_p(32), .beats_p(1), .cnt_width_p(4)) u_dut1 (
    .clk_i(clk), .reset_n_i(reset_n), .bus(b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] dword(input int s);
    return 32'hC0DE_0000 + 32'(s);
  endfunction

  // One full 4-beat packet from slot s; optionally rewrite the enable mask before beat clr_at.
  task automatic run_pkt(input int s, input int clr_at, input logic [3:0] new_mask);
    for (int bt = 0; bt < 4; bt++) begin
      if (bt == clr_at) a.en_mask_i = new_mask;
      #1;
      chk($sformatf("pkt_s%0d_b%0d_slot", s, bt), 64'(a.slot_id_o), 64'(s));
      chk($sformatf("pkt_s%0d_b%0d_last", s, bt), 64'(a.last_o), 64'(bt == 3));
      chk($sformatf("pkt_s%0d_b%0d_yumi", s, bt), 64'(a.yumi_o), 64'(4'b1 << s));
      tick();
    end
  endtask

  initial begin
    n_run   = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    a.en_mask_i = 4'hF;
    a.v_i       = 4'hF;
    a.ready_i   = 1'b1;
    a.data_i    = {dword(3), dword(2), dword(1), dword(0)};
    b.en_mask_i = 4'hF;
    b.v_i       = 4'h0;
    b.ready_i   = 1'b0;
    b.data_i    = {dword(7), dword(6), dword(5), dword(4)};

    tick();
    tick();
    chk("rst_v_o", 64'(a.v_o), 64'd0);
    chk("rst_yumi", 64'(a.yumi_o), 64'd0);
    chk("rst_busy", 64'(a.busy_o), 64'd0);
    chk("rst_data", 64'(a.data_o), 64'd0);
    chk("rst_slot", 64'(a.slot_id_o), 64'd0);
    chk("rst_cnt", a.pkt_cnt_o, 64'd0);

    reset_n = 1'b1;
    #1;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("rr_%0d_slot", k), 64'(a.slot_id_o), 64'(k / 4));
      chk($sformatf("rr_%0d_last", k), 64'(a.last_o), 64'(k % 4 == 3));
      chk($sformatf("rr_%0d_yumi", k), 64'(a.yumi_o), 64'(4'b1 << (k / 4)));
      chk($sformatf("rr_%0d_data", k), 64'(a.data_o), 64'(dword(k / 4)));
      tick();
    end
    chk("rr_cnt", a.pkt_cnt_o, {16'd1, 16'd1, 16'd1, 16'd1});
    chk("rr_wrap_slot", 64'(a.slot_id_o), 64'd0);

    a.v_i = 4'b0100;
    #1;
    chk("il_b1_slot", 64'(a.slot_id_o), 64'd2);
    tick();
    a.v_i = 4'b1101;
    for (int bt = 1; bt < 4; bt++) begin
      #1;
      chk($sformatf("il_b%0d_slot", bt + 1), 64'(a.slot_id_o), 64'd2);
      chk($sformatf("il_b%0d_yumi", bt + 1), 64'(a.yumi_o), 64'b0100);
      chk($sformatf("il_b%0d_last", bt + 1), 64'(a.last_o), 64'(bt == 3));
      tick();
    end
    chk("il_next_slot", 64'(a.slot_id_o), 64'd3);
    chk("il_cnt", a.pkt_cnt_o, {16'd1, 16'd2, 16'd1, 16'd1});

    tick();
    a.ready_i = 1'b0;
    #1;
    chk("bp_r0_yumi", 64'(a.yumi_o), 64'd0);
    chk("bp_r0_busy", 64'(a.busy_o), 64'd1);
    chk("bp_r0_data", 64'(a.data_o), 64'(dword(3)));
    tick();
    a.ready_i = 1'b1;
    #1;
    chk("bp_r1_yumi", 64'(a.yumi_o), 64'b1000);
    chk("bp_r1_last", 64'(a.last_o), 64'd0);
    tick();
    a.ready_i = 1'b0;
    #1;
    chk("bp_r2_yumi", 64'(a.yumi_o), 64'd0);
    tick();
    a.ready_i = 1'b1;
    a.v_i     = 4'b0111;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bub_%0d_v", c), 64'(a.v_o), 64'd0);
      chk($sformatf("bub_%0d_yumi", c), 64'(a.yumi_o), 64'd0);
      chk($sformatf("bub_%0d_busy", c), 64'(a.busy_o), 64'd1);
      chk($sformatf("bub_%0d_slot", c), 64'(a.slot_id_o), 64'd3);
      tick();
    end
    a.v_i = 4'hF;
    #1;
    chk("bp_b3_last", 64'(a.last_o), 64'd0);
    chk("bp_b3_yumi", 64'(a.yumi_o), 64'b1000);
    tick();
    chk("bp_b4_last", 64'(a.last_o), 64'd1);
    chk("bp_b4_data", 64'(a.data_o), 64'(dword(3)));
    tick();
    chk("bp_done_busy", 64'(a.busy_o), 64'd0);
    chk("bp_cnt", a.pkt_cnt_o, {16'd2, 16'd2, 16'd1, 16'd1});

    a.en_mask_i = 4'b0101;
    run_pkt(0, -1, 4'b0101);
    run_pkt(2, 1, 4'b0001);
    run_pkt(0, -1, 4'b0001);
    run_pkt(0, -1, 4'b0001);
    chk("mask_cnt", a.pkt_cnt_o, {16'd2, 16'd3, 16'd1, 16'd4});

    a.en_mask_i = 4'hF;
    #1;
    chk("ar_pick", 64'(a.slot_id_o), 64'd1);
    tick();
    chk("ar_lock_busy", 64'(a.busy_o), 64'd1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("ar_busy", 64'(a.busy_o), 64'd0);
    chk("ar_v_o", 64'(a.v_o), 64'd0);
    chk("ar_cnt", a.pkt_cnt_o, 64'd0);
    tick();
    reset_n = 1'b1;
    a.v_i   = 4'h0;

    b.v_i     = 4'b0010;
    b.ready_i = 1'b1;
    for (int p = 0; p < 17; p++) begin
      #1;
      chk($sformatf("wr_%0d_slot", p), 64'(b.slot_id_o), 64'd1);
      chk($sformatf("wr_%0d_yumi", p), 64'(b.yumi_o), 64'b0010);
      chk($sformatf("wr_%0d_last", p), 64'(b.last_o), 64'd1);
      tick();
    end
    chk("wr_cnt", 64'(b.pkt_cnt_o), 64'h0010);
    chk("wr_busy", 64'(b.busy_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
